// File: rtl/trace_sink_serializer.sv
// Message-to-byte serializer: buffers whole trace messages in a small FIFO and
// streams them out least-significant byte first on a valid/ready byte port.
module trace_sink_serializer #(
  parameter  int DATA_BYTES = 4,
  parameter  int FIFO_DEPTH = 2,
  localparam int LEN_W      = $clog2(DATA_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*DATA_BYTES-1:0] in_data,
  input  logic [LEN_W-1:0]        in_len,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_byte,
  output logic                    out_last,
  output logic [15:0]             msg_count
);

  localparam int DW    = 8 * DATA_BYTES;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [DW-1:0]      mem_data_q [FIFO_DEPTH];
  logic [DW-1:0]      mem_data_d [FIFO_DEPTH];
  logic [LEN_W-1:0]   mem_len_q  [FIFO_DEPTH];
  logic [LEN_W-1:0]   mem_len_d  [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DW-1:0]      data_q, data_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [15:0]        msg_count_q, msg_count_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;

  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [LEN_W-1:0]   len_clamped_s;
  logic               push_s;
  logic               pop_s;
  logic               fire_s;
  logic               is_last_s;

  // Handshake qualifiers; in_ready depends on FIFO occupancy only, so a pop
  // in the same cycle never frees a slot for a concurrent push.
  always_comb begin
    fifo_full_s   = (count_q == CNT_W'(FIFO_DEPTH));
    fifo_empty_s  = (count_q == {CNT_W{1'b0}});
    len_clamped_s = (in_len > LEN_W'(DATA_BYTES)) ? LEN_W'(DATA_BYTES) : in_len;
    push_s        = in_valid & ~fifo_full_s & (len_clamped_s != {LEN_W{1'b0}});
    fire_s        = (state_q == SEND) & out_ready;
    is_last_s     = (idx_q == (len_q - LEN_W'(1)));
    pop_s         = ~fifo_empty_s & ((state_q == IDLE) | (fire_s & is_last_s));
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: back-to-back messages stay in SEND without a bubble
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) state_d = SEND;
        else               state_d = IDLE;
      end
      SEND: begin
        if (fire_s && is_last_s && fifo_empty_s) state_d = IDLE;
        else                                     state_d = SEND;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs, registered so out_valid/out_last come straight from flops
  always_comb begin
    out_valid_d = (state_d == SEND);
    if (pop_s) begin
      out_last_d = (mem_len_q[rd_ptr_q] == LEN_W'(1));
    end else if (fire_s && !is_last_s) begin
      out_last_d = ((idx_q + LEN_W'(1)) == (len_q - LEN_W'(1)));
    end else begin
      out_last_d = out_last_q;
    end
  end

  // FIFO storage, pointers and the byte shift register
  always_comb begin
    mem_data_d = mem_data_q;
    mem_len_d  = mem_len_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_d     = data_q;
    len_d      = len_q;
    idx_d      = idx_q;
    if (push_s) begin
      mem_data_d[wr_ptr_q] = in_data;
      mem_len_d[wr_ptr_q]  = len_clamped_s;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    // The last byte is not shifted out so out_byte holds it once idle.
    if (pop_s) begin
      data_d   = mem_data_q[rd_ptr_q];
      len_d    = mem_len_q[rd_ptr_q];
      idx_d    = {LEN_W{1'b0}};
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else if (fire_s && !is_last_s) begin
      data_d = data_q >> 8;
      idx_d  = idx_q + LEN_W'(1);
    end else begin
      data_d = data_q;
    end
    msg_count_d = msg_count_q + {15'd0, (fire_s & is_last_s)};
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_data_q  <= '{default: {DW{1'b0}}};
      mem_len_q   <= '{default: {LEN_W{1'b0}}};
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      data_q      <= {DW{1'b0}};
      len_q       <= {LEN_W{1'b0}};
      idx_q       <= {LEN_W{1'b0}};
      msg_count_q <= 16'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      mem_data_q  <= mem_data_d;
      mem_len_q   <= mem_len_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_q      <= data_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      msg_count_q <= msg_count_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready  = ~fifo_full_s;
  assign out_valid = out_valid_q;
  assign out_byte  = data_q[7:0];
  assign out_last  = out_last_q;
  assign msg_count = msg_count_q;

endmodule

// File: tb/tb_trace_sink_serializer.sv
// Randomized bench for trace_sink_serializer against a queue-based model of
// message buffering and little-endian byte emission.
module tb_trace_sink_serializer;

  localparam int DATA_BYTES = 4;
  localparam int FIFO_DEPTH = 2;
  localparam int LEN_W      = 3;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [8*DATA_BYTES-1:0] in_data = 32'h0;
  logic [LEN_W-1:0]        in_len = 3'd0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [7:0]              out_byte;
  logic                    out_last;
  logic [15:0]             msg_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: messages waiting in the buffer, bytes of the message on the port.
  logic [31:0] m_data[$];
  int          m_len[$];
  logic [7:0]  cur_bytes[$];
  logic [15:0] exp_cnt = 16'd0;

  trace_sink_serializer #(.DATA_BYTES(DATA_BYTES), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_len(in_len), .out_valid(out_valid),
    .out_ready(out_ready), .out_byte(out_byte), .out_last(out_last),
    .msg_count(msg_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_load();
    logic [31:0] d;
    int l;
    d = m_data.pop_front();
    l = m_len.pop_front();
    for (int i = 0; i < l; i++) cur_bytes.push_back(d[8*i +: 8]);
  endtask

  task automatic model_clear();
    m_data.delete();
    m_len.delete();
    cur_bytes.delete();
    exp_cnt = 16'd0;
  endtask

  // One clock cycle: drive at negedge, check outputs, advance the model.
  task automatic step(input bit v, input logic [31:0] d, input logic [2:0] l, input bit r);
    bit exp_ready;
    int eff_len;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_len    = l;
    out_ready = r;
    #1;
    exp_ready = (m_data.size() < FIFO_DEPTH);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    chk("out_valid", {31'd0, out_valid}, {31'd0, (cur_bytes.size() != 0)});
    chk("msg_count", {16'd0, msg_count}, {16'd0, exp_cnt});
    if (cur_bytes.size() != 0) begin
      chk("out_byte", {24'd0, out_byte}, {24'd0, cur_bytes[0]});
      chk("out_last", {31'd0, out_last}, {31'd0, (cur_bytes.size() == 1)});
    end
    if (cur_bytes.size() != 0 && r) begin
      void'(cur_bytes.pop_front());
      if (cur_bytes.size() == 0) begin
        exp_cnt = exp_cnt + 16'd1;
        if (m_data.size() != 0) model_load();
      end
    end else if (cur_bytes.size() == 0 && m_data.size() != 0) begin
      model_load();
    end
    eff_len = (int'(l) > DATA_BYTES) ? DATA_BYTES : int'(l);
    if (v && exp_ready && eff_len != 0) begin
      m_data.push_back(d);
      m_len.push_back(eff_len);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 3'd0, 1'b1);
  endtask

  initial begin
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_byte", {24'd0, out_byte}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_msg_count", {16'd0, msg_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single 4-byte message: latency 2, bytes LSB first.
    step(1'b1, 32'h44332211, 3'd4, 1'b1);
    step(1'b0, 32'h0, 3'd0, 1'b1);
    chk("latency_idle", {31'd0, out_valid}, 32'd0);
    step(1'b0, 32'h0, 3'd0, 1'b1);
    chk("latency_byte0", {24'd0, out_byte}, 32'h11);
    idle(5);
    chk("single_count", {16'd0, msg_count}, 32'd1);

    // Back-to-back short messages, no bubble at the boundary.
    step(1'b1, 32'h0000BBAA, 3'd2, 1'b1);
    step(1'b1, 32'h000000CC, 3'd1, 1'b1);
    idle(6);
    chk("b2b_count", {16'd0, msg_count}, 32'd3);

    // Stall with three offered messages, then toggle out_ready.
    step(1'b1, 32'hA4A3A2A1, 3'd4, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'hB4B3B2B1 + 32'(i), 3'd3, 1'b0);
    chk("stall_full", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 24; i++) step(1'b0, 32'h0, 3'd0, i[0]);
    idle(4);

    // Zero length discarded, oversize length clamped.
    step(1'b1, 32'hDEADBEEF, 3'd0, 1'b1);
    step(1'b1, 32'h87654321, 3'd7, 1'b1);
    idle(8);

    // Asynchronous reset mid-message with another message queued.
    step(1'b1, 32'h55443322, 3'd4, 1'b1);
    step(1'b1, 32'h99887766, 3'd4, 1'b1);
    step(1'b0, 32'h0, 3'd0, 1'b1);
    step(1'b0, 32'h0, 3'd0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_msg_count", {16'd0, msg_count}, 32'd0);
    chk("arst_out_byte", {24'd0, out_byte}, 32'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    idle(6);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 60), $urandom(), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 99) < 70));
    end
    idle(12);

    // Counter wrap: 65537 single-byte messages after a fresh reset.
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 65537; i++) step(1'b1, $urandom(), 3'd1, 1'b1);
    idle(4);
    chk("wrap_count", {16'd0, msg_count}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trace_sink_serializer.md
Name: trace_sink_serializer

Overview:
Upstream neighbour of the trace sink byte monitor. Accepts whole trace messages (up to DATA_BYTES bytes plus a length) on a valid/ready port and buffers them in a small FIFO. It emits them one byte at a time on a valid/ready byte stream, least-significant byte first. The monitor observes that stream as fire = out_valid & out_ready together with out_byte.

Parameters:
DATA_BYTES, 4, bytes per message word; in_data width = 8*DATA_BYTES; legal range 1..16
FIFO_DEPTH, 2, message FIFO entries; power of two, >= 2
LEN_W, $clog2(DATA_BYTES+1), width of in_len (derived, not overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
in_valid  input  1  message valid
in_ready  output  1  FIFO can accept a message
in_data  input  8*DATA_BYTES  message payload; byte 0 = in_data[7:0]
in_len  input  LEN_W  number of valid bytes, 0..DATA_BYTES
out_valid  output  1  byte valid
out_ready  input  1  downstream accepts byte
out_byte  output  8  current byte
out_last  output  1  current byte is final byte of its message
msg_count  output  16  count of messages whose last byte has fired; wraps 0xFFFF->0

Behaviour:
- Reset values: out_valid=0, out_byte=0, out_last=0, msg_count=0, FIFO empty (in_ready=1), state IDLE, byte index=0. Assertion takes effect without a clock edge.
- Reset mid-message: partially sent message and all FIFO contents are discarded; no byte is replayed after release.
- in_ready = !fifo_full, registered/derived from FIFO state only. There is no combinational path from out_ready or in_valid.
  - A push into a full FIFO is refused even when the serializer pops in the same cycle.
- Accept when in_valid & in_ready:
  - in_len = 0: accepted and discarded (not written, no bytes, msg_count unchanged).
  - in_len > DATA_BYTES: clamped to DATA_BYTES.
  - Otherwise {in_data, len} is written at the FIFO tail.
- FIFO: circular buffer with wrapping read/write pointers plus an occupancy counter 0..FIFO_DEPTH. Simultaneous push and pop keep occupancy unchanged.
- State machine, IDLE / SEND:
  - IDLE: out_valid=0. If FIFO non-empty, pop head into the shift register, set idx=0 and len, go to SEND.
  - SEND: out_valid=1, out_byte = data[8*idx +: 8], out_last = (idx == len-1).
  - SEND, no fire (out_ready=0): out_byte, out_last and out_valid are held stable.
  - SEND, fire on a non-last byte: idx increments.
  - SEND, fire on the last byte: msg_count increments. If FIFO non-empty, the next head is popped in the same edge and SEND continues with idx=0 (no bubble). Otherwise go to IDLE.
- Latency: a message accepted in cycle 0 into an empty FIFO with the serializer IDLE presents byte 0 with out_valid=1 in cycle 2.
- Throughput: one byte per cycle while out_ready=1, including across message boundaries.
- Ordering: messages leave in acceptance order; bytes within a message are little-endian.
- out_byte while out_valid=0: holds its last value (0 after reset). Downstream must ignore it.

Test Plan:
- Reset then push {in_data=0x44332211, in_len=4}, out_ready=1 -> out_valid first high 2 cycles after accept; bytes 0x11,0x22,0x33,0x44 on consecutive cycles; out_last only on 0x44; msg_count=1.
- Push len=2 data=0xBBAA, then len=1 data=0xCC back-to-back, out_ready=1 -> stream 0xAA,0xBB,0xCC with no idle cycle between 0xBB and 0xCC; out_last on 0xBB and 0xCC; msg_count=2.
- out_ready=0 while 3 messages are offered with FIFO_DEPTH=2 -> one message loaded into SEND and 2 buffered, in_ready=0, 4th held off. Toggling out_ready 1/0 -> out_byte stable during stalls, all bytes delivered in order.
- Push len=0 and len=7 (DATA_BYTES=4) -> len=0 produces no bytes and no msg_count change; len=7 emits exactly 4 bytes.
- Assert reset asynchronously after byte 1 of a 4-byte message with another message queued -> out_valid=0, in_ready=1, msg_count=0 immediately. After release no bytes appear until a new push.
- Stream 65537 single-byte messages -> msg_count wraps to 1; with the monitor attached, the output file byte count equals the number of fires.
